// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the OV7670 SCCB configuration sequencer.
package cam_cfg_pkg;

    typedef enum logic [3:0] {
        S_PWRUP,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_DELAY,
        S_NEXT_CAM,
        S_IDLE,
        S_RT_ISSUE,
        S_RT_WAIT
    } seq_state_t;

    localparam logic [15:0] ROM_END   = 16'hFFFF;
    localparam logic [15:0] ROM_DELAY = 16'hFFF0;

    localparam logic CAM_DICE = 1'b0;
    localparam logic CAM_FACE = 1'b1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sccb_wait_counter.sv
// Loadable down-counter with zero flag; load wins over decrement, holds at zero.
module sccb_wait_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cam_sccb_sequencer.sv
// Walks the init ROM once per camera (CAM1 then CAM2) through one SCCB write master, then
// serves run-time writes; requests are level-held until sccb_done, NACKs retried MAX_RETRY times.
module cam_sccb_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int unsigned POWERUP_WAIT = 1_000_000,
    parameter int unsigned MARK_DELAY   = 1_000_000,
    parameter int unsigned ROM_AW       = 7,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reinit_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [15:0]       rom_data_i,
    output logic              sccb_req_o,
    output logic              sccb_cam_o,
    output logic [7:0]        sccb_addr_o,
    output logic [7:0]        sccb_wdata_o,
    input  logic              sccb_done_i,
    input  logic              sccb_nack_i,
    input  logic              rt_req_i,
    input  logic              rt_cam_i,
    input  logic [7:0]        rt_addr_i,
    input  logic [7:0]        rt_data_i,
    output logic              rt_ack_o,
    output logic              rt_err_o,
    output logic [1:0]        cam_ready_o,
    output logic [1:0]        cam_err_o,
    output logic              busy_o
);

    localparam int unsigned CNT_W = $clog2(max_u(POWERUP_WAIT, MARK_DELAY)) + 1;
    localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RTY_W-1:0] RETRY_LAST = RTY_W'(MAX_RETRY);

    seq_state_t        state_q;
    logic [ROM_AW-1:0] rom_addr_q;
    logic [RTY_W-1:0]  retry_q;
    logic              cam_q;
    logic              pwr_armed_q;
    logic              sccb_req_q;
    logic              sccb_cam_q;
    logic [7:0]        sccb_addr_q;
    logic [7:0]        sccb_wdata_q;
    logic              rt_ack_q;
    logic              rt_err_q;
    logic [1:0]        cam_ready_q;
    logic [1:0]        cam_err_q;
    logic              busy_q;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_en;
    logic              cnt_zero;
    logic              rom_inc;

    // One counter serves both the power-up wait and ROM delay markers.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = CNT_W'(MARK_DELAY - 1);
        cnt_en       = 1'b0;
        if (state_q == S_PWRUP) begin
            cnt_load     = !pwr_armed_q;
            cnt_load_val = CNT_W'(POWERUP_WAIT - 1);
            cnt_en       = 1'b1;
        end else if (state_q == S_DECODE) begin
            cnt_load = (rom_data_i == ROM_DELAY);
        end else if (state_q == S_DELAY) begin
            cnt_en = 1'b1;
        end
    end

    sccb_wait_counter #(.W(CNT_W)) u_wait_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .en_i       (cnt_en),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_PWRUP;
            rom_addr_q   <= '0;
            retry_q      <= '0;
            cam_q        <= CAM_DICE;
            pwr_armed_q  <= 1'b0;
            sccb_req_q   <= 1'b0;
            sccb_cam_q   <= CAM_DICE;
            sccb_addr_q  <= '0;
            sccb_wdata_q <= '0;
            rt_ack_q     <= 1'b0;
            rt_err_q     <= 1'b0;
            cam_ready_q  <= 2'b00;
            cam_err_q    <= 2'b00;
            busy_q       <= 1'b1;
        end else begin
            rt_ack_q <= 1'b0;
            rt_err_q <= 1'b0;
            unique case (state_q)
                S_PWRUP: begin
                    pwr_armed_q <= 1'b1;
                    if (pwr_armed_q && cnt_zero) state_q <= S_FETCH;
                end
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    if (rom_data_i == ROM_END) begin
                        state_q <= S_NEXT_CAM;
                    end else if (rom_data_i == ROM_DELAY) begin
                        state_q <= S_DELAY;
                    end else begin
                        sccb_cam_q   <= cam_q;
                        sccb_addr_q  <= rom_data_i[15:8];
                        sccb_wdata_q <= rom_data_i[7:0];
                        sccb_req_q   <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    sccb_req_q <= 1'b1;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (sccb_done_i) begin
                        sccb_req_q <= 1'b0;
                        if (!sccb_nack_i) begin
                            rom_addr_q <= rom_addr_q + ROM_AW'(1);
                            retry_q    <= '0;
                            state_q    <= S_FETCH;
                        end else if (retry_q != RETRY_LAST) begin
                            retry_q <= retry_q + RTY_W'(1);
                            state_q <= S_ISSUE;
                        end else begin
                            retry_q          <= '0;
                            cam_err_q[cam_q] <= 1'b1;
                            state_q          <= S_NEXT_CAM;
                        end
                    end
                end
                S_DELAY: begin
                    if (cnt_zero) begin
                        rom_addr_q <= rom_addr_q + ROM_AW'(1);
                        state_q    <= S_FETCH;
                    end
                end
                S_NEXT_CAM: begin
                    if (!cam_err_q[cam_q]) cam_ready_q[cam_q] <= 1'b1;
                    if (cam_q == CAM_DICE) begin
                        cam_q      <= CAM_FACE;
                        rom_addr_q <= '0;
                        state_q    <= S_FETCH;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    // rt_req stays high through the ack cycle; don't serve it twice.
                    if (reinit_i) begin
                        cam_ready_q <= 2'b00;
                        cam_err_q   <= 2'b00;
                        cam_q       <= CAM_DICE;
                        rom_addr_q  <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= S_FETCH;
                    end else if (rt_req_i && !rt_ack_q) begin
                        sccb_cam_q   <= rt_cam_i;
                        sccb_addr_q  <= rt_addr_i;
                        sccb_wdata_q <= rt_data_i;
                        sccb_req_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_RT_ISSUE;
                    end
                end
                S_RT_ISSUE: begin
                    sccb_req_q <= 1'b1;
                    state_q    <= S_RT_WAIT;
                end
                S_RT_WAIT: begin
                    if (sccb_done_i) begin
                        sccb_req_q <= 1'b0;
                        if (sccb_nack_i && (retry_q != RETRY_LAST)) begin
                            retry_q <= retry_q + RTY_W'(1);
                            state_q <= S_RT_ISSUE;
                        end else begin
                            retry_q  <= '0;
                            rt_ack_q <= 1'b1;
                            rt_err_q <= sccb_nack_i;
                            busy_q   <= 1'b0;
                            state_q  <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_PWRUP;
            endcase
        end
    end

    // A table missing its end marker would walk past the top of the ROM.
    assign rom_inc = ((state_q == S_WAIT) && sccb_done_i && !sccb_nack_i) ||
                     ((state_q == S_DELAY) && cnt_zero);

    a_rom_no_wrap: assert property (@(posedge clk) disable iff (reset) !(rom_inc && (&rom_addr_q)));

    assign rom_addr_o   = rom_addr_q;
    assign sccb_req_o   = sccb_req_q;
    assign sccb_cam_o   = sccb_cam_q;
    assign sccb_addr_o  = sccb_addr_q;
    assign sccb_wdata_o = sccb_wdata_q;
    assign rt_ack_o     = rt_ack_q;
    assign rt_err_o     = rt_err_q;
    assign cam_ready_o  = cam_ready_q;
    assign cam_err_o    = cam_err_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_cam_sccb_sequencer.sv
// Directed bench for cam_sccb_sequencer with a small ROM and an SCCB master model.
module tb_cam_sccb_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reinit = 1'b0;
    logic [6:0] rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic       sccb_req, sccb_cam;
    logic [7:0] sccb_addr, sccb_wdata;
    logic       sccb_done = 1'b0, sccb_nack = 1'b0;
    logic       rt_req = 1'b0, rt_cam = 1'b0;
    logic [7:0] rt_addr = 8'h00, rt_data = 8'h00;
    logic       rt_ack, rt_err;
    logic [1:0] cam_ready, cam_err;
    logic       busy;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;

    cam_sccb_sequencer #(
        .POWERUP_WAIT(16), .MARK_DELAY(8), .ROM_AW(7), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .reset(reset), .reinit_i(reinit),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .sccb_req_o(sccb_req), .sccb_cam_o(sccb_cam),
        .sccb_addr_o(sccb_addr), .sccb_wdata_o(sccb_wdata),
        .sccb_done_i(sccb_done), .sccb_nack_i(sccb_nack),
        .rt_req_i(rt_req), .rt_cam_i(rt_cam), .rt_addr_i(rt_addr), .rt_data_i(rt_data),
        .rt_ack_o(rt_ack), .rt_err_o(rt_err),
        .cam_ready_o(cam_ready), .cam_err_o(cam_err), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered ROM: {0x1280, FFF0, 0x1204, FFFF}, end marker beyond.
    always @(posedge clk) begin
        case (rom_addr)
            7'd0:    rom_data <= 16'h1280;
            7'd1:    rom_data <= 16'hFFF0;
            7'd2:    rom_data <= 16'h1204;
            default: rom_data <= 16'hFFFF;
        endcase
    end

    // SCCB master: answers 3 cycles after req, logs every request it accepts.
    // mode 0: always ack; 1: NACK first two CAM1 0x12/0x04 writes; 2: NACK all CAM2 writes.
    int   mode = 0;
    int   nreq = 0;
    int   m_cnt = 0;
    bit   m_act = 0;
    int   nk = 0;
    logic       lg_cam   [256];
    logic [7:0] lg_addr  [256];
    logic [7:0] lg_data  [256];
    int         lg_start [256];
    int         lg_done  [256];

    always @(negedge clk) begin
        sccb_done = 1'b0;
        sccb_nack = 1'b0;
        if (reset) begin
            m_act = 0;
            nk    = 0;
        end else if (m_act && !sccb_req) begin
            m_act = 0;
        end else if (m_act) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_act     = 0;
                sccb_done = 1'b1;
                if (mode == 1 && !sccb_cam && sccb_addr == 8'h12 && sccb_wdata == 8'h04 && nk < 2) begin
                    sccb_nack = 1'b1;
                    nk++;
                end else if (mode == 2 && sccb_cam) begin
                    sccb_nack = 1'b1;
                end
                lg_done[nreq-1] = cyc;
            end
        end else if (sccb_req) begin
            m_act          = 1;
            m_cnt          = 3;
            lg_cam[nreq]   = sccb_cam;
            lg_addr[nreq]  = sccb_addr;
            lg_data[nreq]  = sccb_wdata;
            lg_start[nreq] = cyc;
            nreq++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL %s_idle: busy=%b, required 0 within %0d cycles", tag, busy, budget);
        end
    endtask

    // Called with reset just released; returns edge index (0 = first edge) of first sccb_req.
    task automatic time_first_req(input string tag);
        int n = 0;
        while (sccb_req !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        vecs++;
        if (n - 1 < 17 || n - 1 > 19) begin
            errs++;
            $display("FAIL %s_first_req: got cycle %0d, required 17..19", tag, n - 1);
        end
    endtask

    task automatic check_entry(input string tag, input int idx, input logic c,
                               input logic [7:0] a, input logic [7:0] d);
        vecs++;
        if (lg_cam[idx] !== c || lg_addr[idx] !== a || lg_data[idx] !== d) begin
            errs++;
            $display("FAIL %s_req%0d: got cam=%b %h/%h, required cam=%b %h/%h",
                     tag, idx, lg_cam[idx], lg_addr[idx], lg_data[idx], c, a, d);
        end
    endtask

    task automatic wait_rt_ack(input string tag, output bit seen);
        int n = 0;
        seen = 0;
        while (n < 600 && !seen) begin
            step();
            n++;
            if (rt_ack === 1'b1) seen = 1;
        end
        vecs++;
        if (!seen) begin
            errs++;
            $display("FAIL %s_rt_ack: got no rt_ack, required one within 600 cycles", tag);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        vecs += 7;
        if (sccb_req !== 1'b0)     begin errs++; $display("FAIL rst_req: got %b, required 0", sccb_req); end
        if (rom_addr !== 7'd0)     begin errs++; $display("FAIL rst_rom_addr: got %0d, required 0", rom_addr); end
        if (rt_ack !== 1'b0)       begin errs++; $display("FAIL rst_rt_ack: got %b, required 0", rt_ack); end
        if (rt_err !== 1'b0)       begin errs++; $display("FAIL rst_rt_err: got %b, required 0", rt_err); end
        if (cam_ready !== 2'b00)   begin errs++; $display("FAIL rst_cam_ready: got %b, required 00", cam_ready); end
        if (cam_err !== 2'b00)     begin errs++; $display("FAIL rst_cam_err: got %b, required 00", cam_err); end
        if (busy !== 1'b1)         begin errs++; $display("FAIL rst_busy: got %b, required 1", busy); end
    endtask

    task automatic test_boot();
        int base;
        mode = 0;
        base = nreq;
        reset = 1'b0;
        time_first_req("boot");
        wait_idle(500, "boot");
        vecs++;
        if (nreq - base != 4) begin errs++; $display("FAIL boot_nreq: got %0d, required 4", nreq - base); end
        check_entry("boot", base + 0, 1'b0, 8'h12, 8'h80);
        check_entry("boot", base + 1, 1'b0, 8'h12, 8'h04);
        check_entry("boot", base + 2, 1'b1, 8'h12, 8'h80);
        check_entry("boot", base + 3, 1'b1, 8'h12, 8'h04);
        vecs += 3;
        if (lg_start[base+1] - lg_done[base] < 8) begin
            errs++; $display("FAIL boot_delay_gap: got %0d cycles, required >=8", lg_start[base+1] - lg_done[base]);
        end
        if (cam_ready !== 2'b11) begin errs++; $display("FAIL boot_cam_ready: got %b, required 11", cam_ready); end
        if (cam_err !== 2'b00)   begin errs++; $display("FAIL boot_cam_err: got %b, required 00", cam_err); end
    endtask

    task automatic test_nack_retry();
        int base;
        mode = 1;
        apply_reset();
        base = nreq;
        wait_idle(600, "retry");
        vecs++;
        if (nreq - base != 6) begin errs++; $display("FAIL retry_nreq: got %0d, required 6", nreq - base); end
        check_entry("retry", base + 0, 1'b0, 8'h12, 8'h80);
        for (int k = 1; k <= 3; k++) check_entry("retry", base + k, 1'b0, 8'h12, 8'h04);
        check_entry("retry", base + 5, 1'b1, 8'h12, 8'h04);
        vecs += 2;
        if (cam_ready !== 2'b11) begin errs++; $display("FAIL retry_cam_ready: got %b, required 11", cam_ready); end
        if (cam_err !== 2'b00)   begin errs++; $display("FAIL retry_cam_err: got %b, required 00", cam_err); end
    endtask

    task automatic test_cam2_fail();
        int base;
        mode = 2;
        apply_reset();
        base = nreq;
        wait_idle(600, "cam2fail");
        vecs++;
        if (nreq - base != 6) begin errs++; $display("FAIL cam2fail_nreq: got %0d, required 6", nreq - base); end
        for (int k = 2; k <= 5; k++) check_entry("cam2fail", base + k, 1'b1, 8'h12, 8'h80);
        vecs += 2;
        if (cam_err !== 2'b10)   begin errs++; $display("FAIL cam2fail_cam_err: got %b, required 10", cam_err); end
        if (cam_ready !== 2'b01) begin errs++; $display("FAIL cam2fail_cam_ready: got %b, required 01", cam_ready); end
    endtask

    task automatic test_rt_during_boot();
        int base;
        bit seen;
        mode = 0;
        apply_reset();
        base = nreq;
        rt_cam = 1'b1;
        rt_addr = 8'h3A;
        rt_data = 8'h04;
        rt_req = 1'b1;
        wait_rt_ack("rtboot", seen);
        vecs += 2;
        if (cam_ready !== 2'b11) begin errs++; $display("FAIL rtboot_ack_early: cam_ready=%b at rt_ack, required 11", cam_ready); end
        if (rt_err !== 1'b0)     begin errs++; $display("FAIL rtboot_rt_err: got %b, required 0", rt_err); end
        rt_req = 1'b0;
        step();
        vecs += 2;
        if (rt_ack !== 1'b0) begin errs++; $display("FAIL rtboot_ack_width: got %b, required 0", rt_ack); end
        if (nreq - base != 5) begin errs++; $display("FAIL rtboot_nreq: got %0d, required 5", nreq - base); end
        check_entry("rtboot", base + 4, 1'b1, 8'h3A, 8'h04);
    endtask

    task automatic test_reset_mid();
        int base;
        int n = 0;
        mode = 0;
        apply_reset();
        while (!(sccb_req === 1'b1 && sccb_cam === 1'b0 && sccb_wdata === 8'h04) && n < 200) begin
            step();
            n++;
        end
        vecs++;
        if (n >= 200) begin errs++; $display("FAIL rstmid_reach: got no CAM1 0x04 request, required one within 200 cycles"); end
        reset = 1'b1;
        step();
        vecs += 3;
        if (sccb_req !== 1'b0)   begin errs++; $display("FAIL rstmid_req: got %b, required 0", sccb_req); end
        if (cam_ready !== 2'b00) begin errs++; $display("FAIL rstmid_cam_ready: got %b, required 00", cam_ready); end
        if (busy !== 1'b1)       begin errs++; $display("FAIL rstmid_busy: got %b, required 1", busy); end
        base = nreq;
        reset = 1'b0;
        time_first_req("rstmid");
        wait_idle(500, "rstmid");
        check_entry("rstmid", base, 1'b0, 8'h12, 8'h80);
        vecs++;
        if (cam_ready !== 2'b11) begin errs++; $display("FAIL rstmid_final_ready: got %b, required 11", cam_ready); end
    endtask

    task automatic test_reinit_vs_rt();
        int base;
        int t0;
        bit seen;
        base = nreq;
        t0 = cyc;
        rt_cam = 1'b1;
        rt_addr = 8'h3A;
        rt_data = 8'h04;
        rt_req = 1'b1;
        reinit = 1'b1;
        step();
        reinit = 1'b0;
        vecs += 3;
        if (cam_ready !== 2'b00) begin errs++; $display("FAIL reinit_clear: cam_ready=%b, required 00", cam_ready); end
        if (busy !== 1'b1)       begin errs++; $display("FAIL reinit_busy: got %b, required 1", busy); end
        if (rom_addr !== 7'd0)   begin errs++; $display("FAIL reinit_rom_addr: got %0d, required 0", rom_addr); end
        wait_rt_ack("reinit", seen);
        vecs++;
        if (cam_ready !== 2'b11) begin errs++; $display("FAIL reinit_ack_early: cam_ready=%b at rt_ack, required 11", cam_ready); end
        rt_req = 1'b0;
        step();
        vecs += 2;
        if (nreq - base != 5) begin errs++; $display("FAIL reinit_nreq: got %0d, required 5", nreq - base); end
        if (lg_start[base] - t0 >= 12) begin
            errs++; $display("FAIL reinit_no_pwrup: first req %0d cycles after reinit, required <12", lg_start[base] - t0);
        end
        check_entry("reinit", base + 0, 1'b0, 8'h12, 8'h80);
        check_entry("reinit", base + 4, 1'b1, 8'h3A, 8'h04);
    endtask

    initial begin
        test_reset();
        test_boot();
        test_nack_retry();
        test_cam2_fail();
        test_rt_during_boot();
        test_reset_mid();
        test_reinit_vs_rt();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
